sobel_frame_ctrl: RTL and testbench
===================================

# sobel_frame_ctrl

Frame sequencer between the SPI pixel front end and the Sobel filter core. It turns the per-pixel receive strobe from the SPI controller into a qualified, coordinate-tagged pixel stream for the core. It tracks pixels in flight through the core, flushes the core's line buffers at end of frame, and generates the transmit-load strobe back to the SPI controller. It also reports frame completion and sticky protocol errors.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥2)
- CW, $clog2(IMG_WIDTH), column counter width
- RW, $clog2(IMG_HEIGHT), row counter width
- FW, $clog2(2*IMG_WIDTH+4), in-flight counter width

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- nreset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  frame enable; low forces IDLE and clears errors
- px_rdy_i  in  1  one-cycle strobe: new input pixel latched by SPI controller
- core_in_valid_o  out  1  one-cycle push into Sobel core
- core_dummy_o  out  1  push is a flush dummy (valid only with core_in_valid_o)
- core_sof_o  out  1  push is pixel (0,0)
- core_eol_o  out  1  push is last pixel of a line
- col_o  out  CW  column of current push
- row_o  out  RW  row of current push
- core_out_valid_i  in  1  one-cycle strobe: core produced an output pixel
- px_rdy_o  out  1  one-cycle strobe to SPI controller: load output pixel into TX
- busy_o  out  1  high in RUN, FLUSH or DRAIN
- frame_done_o  out  1  one-cycle pulse at frame completion
- error_o  out  1  sticky overrun/underflow flag

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE: px_rdy_i with enable_i high → push pixel (0,0) with core_sof_o; go to RUN. px_rdy_i with enable_i low is ignored and raises no error.
- RUN: each px_rdy_i → one push tagged with the current col/row. Column wraps at IMG_WIDTH-1 with core_eol_o. Row increments on wrap. Pushing (IMG_WIDTH-1, IMG_HEIGHT-1) → FLUSH.
- FLUSH: issues IMG_WIDTH+1 dummy pushes, one per cycle, core_dummy_o=1. col/row continue incrementing past the frame, modulo 2^CW and 2^RW. Then → DRAIN.
- DRAIN: wait for in-flight==0 → DONE.
- DONE: frame_done_o=1 for one cycle → IDLE, with counters cleared.
- In-flight counter:
  - +1 per push, real or dummy.
  - −1 per core_out_valid_i.
  - Simultaneous push and output → unchanged.
  - Saturates at 2^FW−1 and sets error_o.
- Core outputs caused by dummy pushes still produce px_rdy_o. The host reads exactly IMG_WIDTH*IMG_HEIGHT + IMG_WIDTH + 1 outputs per frame.
- Errors (set error_o, event otherwise dropped):
  - px_rdy_i in FLUSH, DRAIN or DONE.
  - core_out_valid_i while in-flight==0; the counter stays at 0.
- enable_i low in any state → IDLE next cycle. Counters, in-flight count and error_o are cleared. No frame_done_o is emitted. An output arriving in the same cycle still produces px_rdy_o.

## Timing
- Reset values: all outputs 0; state IDLE; col/row/in-flight 0.
- px_rdy_i at cycle n → core_in_valid_o (with col/row/sof/eol) at cycle n+1, registered.
- core_out_valid_i at cycle n → px_rdy_o at cycle n+1, registered, in every state.
- Back-to-back px_rdy_i on consecutive cycles is legal. Each strobe produces exactly one push.
- Last real push at cycle n → first dummy push at n+1; dummies on consecutive cycles.
- DRAIN exit: in-flight reaches 0 at edge n → DONE at n+1 → frame_done_o high during n+1 → IDLE at n+2.
- busy_o is a registered decode of the state.

## Configuration
- SOBEL_FRAME_CTRL_FLUSH_EN defined: FLUSH state present as above.
- Macro undefined:
  - Last real push goes directly to DRAIN.
  - No dummy pushes are issued; core_dummy_o is tied to 0.
  - Expected outputs per frame equal the number of core outputs actually produced.

## Test plan
Params for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=3.
- Reset, then 12 px_rdy_i strobes spaced 3 cycles, core echoing each push after 2 cycles → pushes carry (0,0)…(3,2), sof only on the first, eol on col 3. With FLUSH_EN: 5 dummies. 17 px_rdy_o pulses, then one frame_done_o; busy_o low afterwards.
- 12 back-to-back px_rdy_i strobes → 12 consecutive pushes, each one cycle after its strobe; no error.
- px_rdy_i during FLUSH → error_o=1 and stays 1. Push count is unchanged. enable_i low for 1 cycle → error_o=0, state IDLE.
- core_out_valid_i with no push outstanding → error_o=1, in-flight stays 0, px_rdy_o still pulses one cycle later.
- enable_i dropped after 6 pixels → IDLE next cycle, no frame_done_o. Next px_rdy_i with enable high → push at (0,0) with sof.
- nreset_i asserted mid-RUN (after pixel 5) → all outputs 0 immediately. After release, a new frame starts at (0,0).

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the SPI pixel front end and the Sobel core: tags pushes with
// col/row, tracks pixels in flight, drains the core and pulses frame completion.
// Define SOBEL_FRAME_CTRL_FLUSH_EN to add IMG_WIDTH+1 line-buffer flush dummies per frame.
module sobel_frame_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT),
    parameter int FW         = $clog2(2*IMG_WIDTH+4)
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic          enable_i,
    input  logic          px_rdy_i,
    output logic          core_in_valid_o,
    output logic          core_dummy_o,
    output logic          core_sof_o,
    output logic          core_eol_o,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    input  logic          core_out_valid_i,
    output logic          px_rdy_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          error_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] INFL_MAX = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] inflight_q, inflight_d;
    logic          error_q, error_d;

    logic          in_valid_q, in_valid_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [CW-1:0] col_out_q, col_out_d;
    logic [RW-1:0] row_out_q, row_out_d;
    logic          px_rdy_q, px_rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          push;
    logic          push_sof;

`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
    localparam int FLW = $clog2(IMG_WIDTH + 1);
    localparam logic [FLW-1:0] FLUSH_LAST = FLW'(IMG_WIDTH);

    logic [FLW-1:0] flush_cnt_q, flush_cnt_d;
    logic           dummy_q, dummy_d;
    logic           push_dummy;
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        inflight_d = inflight_q;
        error_d    = error_q;
        push       = 1'b0;
        push_sof   = 1'b0;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
        push_dummy  = 1'b0;
        flush_cnt_d = flush_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (px_rdy_i) begin
                    push     = 1'b1;
                    push_sof = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (px_rdy_i) begin
                    push = 1'b1;
                    if (col_q == COL_LAST && row_q == ROW_LAST) begin
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
                        state_d = ST_FLUSH;
`else
                        state_d = ST_DRAIN;
`endif
                    end
                end
            end
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
            ST_FLUSH: begin
                push       = 1'b1;
                push_dummy = 1'b1;
                if (px_rdy_i) begin
                    error_d = 1'b1;
                end
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
`endif
            ST_DRAIN: begin
                if (px_rdy_i) begin
                    error_d = 1'b1;
                end
                if (inflight_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (px_rdy_i) begin
                    error_d = 1'b1;
                end
                col_d   = '0;
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dummies keep walking the raster past the last line so the core sees a coherent position.
        if (push) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case ({push, core_out_valid_i})
            2'b10: begin
                if (inflight_q == INFL_MAX) begin
                    error_d = 1'b1;
                end else begin
                    inflight_d = inflight_q + 1'b1;
                end
            end
            2'b01: begin
                if (inflight_q == '0) begin
                    error_d = 1'b1;
                end else begin
                    inflight_d = inflight_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (!enable_i) begin
            state_d    = ST_IDLE;
            col_d      = '0;
            row_d      = '0;
            inflight_d = '0;
            error_d    = 1'b0;
            push       = 1'b0;
            push_sof   = 1'b0;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
            push_dummy  = 1'b0;
            flush_cnt_d = '0;
`endif
        end

        in_valid_d = push;
        sof_d      = push_sof;
        eol_d      = push && (col_q == COL_LAST);
        col_out_d  = push ? col_q : '0;
        row_out_d  = push ? row_q : '0;
        px_rdy_d   = core_out_valid_i;
        busy_d     = (state_d == ST_RUN) || (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
        dummy_d    = push_dummy;
`endif
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= '0;
            error_q    <= 1'b0;
            in_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            col_out_q  <= '0;
            row_out_q  <= '0;
            px_rdy_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
            flush_cnt_q <= '0;
            dummy_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            error_q    <= error_d;
            in_valid_q <= in_valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            col_out_q  <= col_out_d;
            row_out_q  <= row_out_d;
            px_rdy_q   <= px_rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
            dummy_q     <= dummy_d;
`endif
        end
    end

    assign core_in_valid_o = in_valid_q;
    assign core_sof_o      = sof_q;
    assign core_eol_o      = eol_q;
    assign col_o           = col_out_q;
    assign row_o           = row_out_q;
    assign px_rdy_o        = px_rdy_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = done_q;
    assign error_o         = error_q;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
    assign core_dummy_o    = dummy_q;
`else
    assign core_dummy_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 4x3 frame: a core stand-in echoes every push two cycles
// later; observed push/output/done streams are compared with arithmetic expectations.
module tb_sobel_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);
    localparam int NPIX = W * H;
`ifdef SOBEL_FRAME_CTRL_FLUSH_EN
    localparam int NDUM = W + 1;
`else
    localparam int NDUM = 0;
`endif
    localparam int NPUSH = NPIX + NDUM;

    logic          clk = 1'b0;
    logic          nreset_i;
    logic          enable_i;
    logic          px_rdy_i;
    logic          core_out_valid_i;
    logic          core_in_valid_o;
    logic          core_dummy_o;
    logic          core_sof_o;
    logic          core_eol_o;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;
    logic          px_rdy_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          error_o;

    sobel_frame_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk_i           (clk),
        .nreset_i        (nreset_i),
        .enable_i        (enable_i),
        .px_rdy_i        (px_rdy_i),
        .core_in_valid_o (core_in_valid_o),
        .core_dummy_o    (core_dummy_o),
        .core_sof_o      (core_sof_o),
        .core_eol_o      (core_eol_o),
        .col_o           (col_o),
        .row_o           (row_o),
        .core_out_valid_i(core_out_valid_i),
        .px_rdy_o        (px_rdy_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] push_q[$];
    int          pxo_q[$];
    int          done_q[$];
    int          strobe_q[$];
    int          echo_q[$];
    int          force_cyc = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] push_word(input int c, input logic d, input logic s,
                                              input logic e, input int col, input int row);
        return 64'({c, d, s, e, col[CW-1:0], row[RW-1:0]});
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({core_in_valid_o, core_dummy_o, core_sof_o, core_eol_o, col_o, row_o,
                    px_rdy_o, busy_o, frame_done_o, error_o});
    endfunction

    always @(negedge clk) begin
        if (nreset_i === 1'b1) begin
            if (core_in_valid_o) begin
                push_q.push_back(push_word(cyc, core_dummy_o, core_sof_o, core_eol_o,
                                           int'(col_o), int'(row_o)));
                echo_q.push_back(cyc + 2);
            end
            if (px_rdy_o) pxo_q.push_back(cyc);
            if (frame_done_o) done_q.push_back(cyc);
        end
    end

    // Core stand-in: one output per push, two cycles later, plus an optional stray output.
    initial begin
        core_out_valid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_out_valid_i = 1'b0;
            if (echo_q.size() > 0 && echo_q[0] == cyc) begin
                core_out_valid_i = 1'b1;
                void'(echo_q.pop_front());
            end
            if (force_cyc == cyc) core_out_valid_i = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input int gap);
        px_rdy_i = 1'b1;
        strobe_q.push_back(cyc);
        tick();
        px_rdy_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_logs();
        push_q.delete();
        pxo_q.delete();
        done_q.delete();
        strobe_q.delete();
    endtask

    // Pixel k of the frame sits at raster position k; dummy d continues at position NPIX+d.
    task automatic check_frame(input string name, input logic exp_err);
        int          guard;
        int          last_push;
        int          c;
        logic [63:0] exp_word;
        guard = 0;
        while (done_q.size() == 0 && guard < 400) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        check_eq({name, "_done_count"}, done_q.size(), 1);
        check_eq({name, "_push_count"}, push_q.size(), NPUSH);
        check_eq({name, "_pxo_count"}, pxo_q.size(), NPUSH);
        last_push = 0;
        for (int i = 0; i < NPUSH; i++) begin
            if (i < NPIX) c = strobe_q[i] + 1;
            else          c = strobe_q[NPIX-1] + 1 + (i - NPIX + 1);
            exp_word = push_word(c, i >= NPIX, i == 0, (i % W) == W - 1,
                                 i % W, (i / W) % (1 << RW));
            if (i < push_q.size())
                check_eq($sformatf("%s_push%0d", name, i), push_q[i], exp_word);
            if (i < pxo_q.size())
                check_eq($sformatf("%s_pxo%0d", name, i), pxo_q[i], c + 3);
            last_push = c;
        end
        if (done_q.size() > 0) check_eq({name, "_done_cycle"}, done_q[0], last_push + 4);
        check_eq({name, "_busy_idle"}, busy_o, 1'b0);
        check_eq({name, "_error"}, error_o, exp_err);
    endtask

    initial begin
        int fc;
        nreset_i = 1'b0;
        enable_i = 1'b1;
        px_rdy_i = 1'b0;
        repeat (3) tick();
        check_eq("reset_outputs", all_outs(), 64'd0);
        nreset_i = 1'b1;
        tick();

        clear_logs();
        repeat (NPIX) send_px(2);
        check_frame("spaced", 1'b0);

        clear_logs();
        repeat (NPIX) send_px(0);
        check_frame("b2b", 1'b0);

        // Extra strobe right after the last pixel lands in FLUSH (or DRAIN) and is dropped.
        clear_logs();
        repeat (NPIX) send_px(0);
        px_rdy_i = 1'b1;
        tick();
        px_rdy_i = 1'b0;
        check_eq("late_px_err", error_o, 1'b1);
        check_frame("late_px", 1'b1);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        check_eq("late_px_err_clr", error_o, 1'b0);
        check_eq("late_px_idle", busy_o, 1'b0);

        clear_logs();
        force_cyc = cyc + 1;
        fc = force_cyc;
        tick();
        tick();
        check_eq("stray_out_err", error_o, 1'b1);
        check_eq("stray_out_pxo", px_rdy_o, 1'b1);
        check_eq("stray_out_pxo_cyc", cyc, fc + 1);
        tick();
        check_eq("stray_out_pxo_once", px_rdy_o, 1'b0);
        clear_logs();
        repeat (NPIX) send_px(2);
        check_frame("after_stray", 1'b1);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        check_eq("stray_err_clr", error_o, 1'b0);

        clear_logs();
        repeat (6) send_px(2);
        tick();
        enable_i = 1'b0;
        check_eq("drop_busy_before", busy_o, 1'b1);
        tick();
        enable_i = 1'b1;
        check_eq("drop_busy_after", busy_o, 1'b0);
        repeat (20) tick();
        check_eq("drop_no_done", done_q.size(), 0);
        check_eq("drop_push_count", push_q.size(), 6);
        check_eq("drop_err", error_o, 1'b0);
        clear_logs();
        repeat (NPIX) send_px(2);
        check_frame("after_drop", 1'b0);

        clear_logs();
        repeat (4) send_px(2);
        px_rdy_i = 1'b1;
        tick();
        px_rdy_i = 1'b0;
        check_eq("pre_reset_push", core_in_valid_o, 1'b1);
        nreset_i = 1'b0;
        echo_q.delete();
        #1;
        check_eq("async_reset_outputs", all_outs(), 64'd0);
        tick();
        tick();
        check_eq("held_reset_outputs", all_outs(), 64'd0);
        nreset_i = 1'b1;
        tick();
        clear_logs();
        repeat (NPIX) send_px(($urandom % 2) * 2);
        check_frame("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
